referee: RTL and testbench
==========================

Name: referee

Overview:
- Game-rules stage between the ball/paddle generators and the screen driver.
- Samples ball position, ball direction and both paddle bitmaps once per game tick.
- Issues bounce and serve commands back to the ball and keeps both scores.
- Sequences serve → play → point → game-over; score and freeze outputs feed the screen/ball stages.

Parameters:
- SCORE_MAX, 9: points needed to win; score_l/score_r never exceed it.
- SERVE_DELAY, 1000: game ticks spent in SERVE_WAIT before the serve pulse (1 s at a 1 kHz tick).
- DELAY_W, 10: width of the serve down-counter; must satisfy 2^DELAY_W > SERVE_DELAY.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-tick strobe, synchronous to clk
- ball_x  in  4  ball column 0..15
- ball_y  in  4  ball row 0..15
- ball_left  in  1  1 = ball moving toward column 0
- ball_up  in  1  1 = ball moving toward row 0
- lpaddle  in  16  left paddle bitmap, bit r set = row r occupied (column 0)
- rpaddle  in  16  right paddle bitmap (column 15)
- restart  in  1  one-cycle pulse, leaves GAME_OVER
- bounce_x  out  1  one-cycle pulse: ball reverses horizontal direction
- bounce_y  out  1  one-cycle pulse: ball reverses vertical direction
- serve  out  1  one-cycle pulse: ball reloads to centre (7,7)
- serve_left  out  1  direction for serve, valid while serve=1
- freeze  out  1  1 = ball must hold position
- score_l  out  4  left player score
- score_r  out  4  right player score
- game_over  out  1  level, 1 in GAME_OVER
- winner  out  1  valid when game_over: 0 = left, 1 = right

Behaviour:
- Reset (reset=0, async): state SERVE_WAIT, counter=SERVE_DELAY, scores 0, next serve direction right (serve_left=0), all pulses 0, freeze=1, game_over=0, winner=0.
- All outputs are registered. Inputs are sampled only on cycles with tick=1; a response appears exactly 1 clk after the tick cycle. Without a tick, outputs hold, except pulses, which last 1 cycle.
- SERVE_WAIT: each tick decrements the counter.
  - Tick with counter==1: serve=1, serve_left=stored direction, freeze→0, next state PLAY.
  - SERVE_DELAY=0 is treated as 1.
- PLAY, evaluated per tick; rules are independent and may fire together:
  - ball_y==0 && ball_up, or ball_y==15 && !ball_up → bounce_y.
  - ball_x==1 && ball_left: lpaddle[ball_y]=1 → bounce_x; else → right scores, go to POINT.
  - ball_x==14 && !ball_left: rpaddle[ball_y]=1 → bounce_x; else → left scores, go to POINT.
  - A miss suppresses a bounce_y in the same tick.
  - Positions outside these conditions produce no action.
- POINT, one clk, no tick needed:
  - Increment the scorer's score; freeze=1.
  - Stored serve direction = toward the player who conceded (left conceded → serve_left=1).
  - New score == SCORE_MAX → GAME_OVER with winner set; else SERVE_WAIT with counter reloaded.
- GAME_OVER: freeze=1, game_over=1; ticks are ignored.
  - restart=1 → scores 0, serve direction right, SERVE_WAIT with counter reloaded.
  - restart is ignored in all other states.
- Scores saturate at SCORE_MAX, no wrap.
- Paddle bitmaps are used as given; an all-zero bitmap means every ball reaching that column misses.
- Reset asserted mid-rally or mid-countdown returns to the reset state immediately. No pulse may be emitted in the cycle reset deasserts.

Decomposition:
- Shared package pong_pkg:
  - state enum {SERVE_WAIT, PLAY, POINT, GAME_OVER}
  - GRID_MAX=15
  - LHIT_COL=1, RHIT_COL=14
  - CENTRE=7
- One sub-module: serve_timer. Loadable down-counter of DELAY_W bits with load, tick-enable and done (count==1 && tick) outputs.

Test Plan:
- Reset, SERVE_DELAY=3, 3 ticks → serve pulse 1 clk after the 3rd tick, serve_left=0, freeze falls; no serve after only 2 ticks.
- PLAY, ball (1,5) left, lpaddle=16'h0020 → bounce_x only. Same with lpaddle=16'h0040 → score_r=1, freeze=1, next serve_left=1 after the countdown.
- PLAY, ball (14,15) moving right and down, rpaddle bit15 set → bounce_x and bounce_y in the same cycle.
- PLAY, ball (1,0) moving left and up, lpaddle=0 → miss only, no bounce_y, score_r increments.
- SCORE_MAX=2, left wins 2 rallies → game_over=1, winner=0, score_l=2. Further ticks change nothing; restart → scores 0, state SERVE_WAIT.
- Reset pulled low for 1 clk mid-countdown with score_l=1 → all outputs at reset values asynchronously; countdown restarts at SERVE_DELAY.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared game constants, the FSM state type and a saturating score helper.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        POINT      = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] GRID_MAX = 4'd15;
    localparam logic [3:0] LHIT_COL = 4'd1;
    localparam logic [3:0] RHIT_COL = 4'd14;
    localparam logic [3:0] CENTRE   = 4'd7;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v < lim) ? v + 4'd1 : v;
    endfunction

endpackage

// File: rtl/serve_timer.sv
// Loadable tick-enabled down-counter; done flags the tick that sees count==1.
// Latency: done is combinational from the registered count and the tick.
// Backpressure: none; load overrides tick.
module serve_timer #(
    parameter int DELAY_W = 10,
    parameter int RELOAD  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [DELAY_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= DELAY_W'(RELOAD);
        end else if (load) begin
            count <= DELAY_W'(RELOAD);
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick && (count == DELAY_W'(1));

endmodule

// File: rtl/referee.sv
// Pong rules engine: serve countdown, paddle/wall bounces, scoring, game over.
// Latency: every response is registered, 1 clk after the sampling tick.
// Backpressure: none; inputs are only looked at on tick cycles.
module referee
    import pong_pkg::*;
#(
    parameter int SCORE_MAX   = 9,
    parameter int SERVE_DELAY = 1000,
    parameter int DELAY_W     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  ball_x,
    input  logic [3:0]  ball_y,
    input  logic        ball_left,
    input  logic        ball_up,
    input  logic [15:0] lpaddle,
    input  logic [15:0] rpaddle,
    input  logic        restart,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        serve,
    output logic        serve_left,
    output logic        freeze,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output logic        winner
);

    // A zero delay would never hit count==1, so it behaves as a single tick.
    localparam int         DELAY_EFF = (SERVE_DELAY < 1) ? 1 : SERVE_DELAY;
    localparam logic [3:0] SMAX      = 4'(SCORE_MAX);

    state_t state, state_nxt;
    logic   scorer_r, scorer_r_nxt;
    logic   serve_dir, serve_dir_nxt;

    logic       bounce_x_d, bounce_y_d, serve_d, serve_left_d, freeze_d;
    logic       game_over_d, winner_d;
    logic [3:0] score_l_d, score_r_d;

    logic       play_tick, y_edge, l_reach, r_reach, l_hit, r_hit, l_miss, r_miss, miss;
    logic       timer_load, timer_tick, timer_done, win;
    logic [3:0] new_l, new_r;

    assign play_tick = tick && (state == PLAY);
    assign y_edge    = ((ball_y == 4'd0) && ball_up) || ((ball_y == GRID_MAX) && !ball_up);
    assign l_reach   = (ball_x == LHIT_COL) && ball_left;
    assign r_reach   = (ball_x == RHIT_COL) && !ball_left;
    assign l_hit     = l_reach && lpaddle[ball_y];
    assign r_hit     = r_reach && rpaddle[ball_y];
    assign l_miss    = l_reach && !lpaddle[ball_y];
    assign r_miss    = r_reach && !rpaddle[ball_y];
    assign miss      = l_miss || r_miss;

    // scorer_r remembers who won the rally between the miss tick and POINT.
    assign new_l = scorer_r ? score_l : sat_inc(score_l, SMAX);
    assign new_r = scorer_r ? sat_inc(score_r, SMAX) : score_r;
    assign win   = scorer_r ? (new_r == SMAX) : (new_l == SMAX);

    assign timer_load = ((state == POINT) && !win) || ((state == GAME_OVER) && restart);
    assign timer_tick = tick && (state == SERVE_WAIT);

    serve_timer #(
        .DELAY_W (DELAY_W),
        .RELOAD  (DELAY_EFF)
    ) u_serve_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .tick  (timer_tick),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SERVE_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SERVE_WAIT: if (timer_done) state_nxt = PLAY;
            PLAY:       if (play_tick && miss) state_nxt = POINT;
            POINT:      state_nxt = win ? GAME_OVER : SERVE_WAIT;
            GAME_OVER:  if (restart) state_nxt = SERVE_WAIT;
            default:    state_nxt = SERVE_WAIT;
        endcase
    end

    always_comb begin
        bounce_x_d    = play_tick && (l_hit || r_hit);
        bounce_y_d    = play_tick && y_edge && !miss;
        serve_d       = timer_done;
        serve_left_d  = serve_left;
        freeze_d      = freeze;
        score_l_d     = score_l;
        score_r_d     = score_r;
        game_over_d   = game_over;
        winner_d      = winner;
        scorer_r_nxt  = scorer_r;
        serve_dir_nxt = serve_dir;
        case (state)
            SERVE_WAIT: begin
                if (timer_done) begin
                    serve_left_d = serve_dir;
                    freeze_d     = 1'b0;
                end
            end
            PLAY: begin
                if (play_tick && miss) begin
                    freeze_d     = 1'b1;
                    scorer_r_nxt = l_miss;
                end
            end
            POINT: begin
                score_l_d     = new_l;
                score_r_d     = new_r;
                freeze_d      = 1'b1;
                serve_dir_nxt = scorer_r;
                if (win) begin
                    game_over_d = 1'b1;
                    winner_d    = scorer_r;
                end
            end
            GAME_OVER: begin
                if (restart) begin
                    score_l_d     = 4'd0;
                    score_r_d     = 4'd0;
                    serve_dir_nxt = 1'b0;
                    game_over_d   = 1'b0;
                    winner_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            serve      <= 1'b0;
            serve_left <= 1'b0;
            freeze     <= 1'b1;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            scorer_r   <= 1'b0;
            serve_dir  <= 1'b0;
        end else begin
            bounce_x   <= bounce_x_d;
            bounce_y   <= bounce_y_d;
            serve      <= serve_d;
            serve_left <= serve_left_d;
            freeze     <= freeze_d;
            score_l    <= score_l_d;
            score_r    <= score_r_d;
            game_over  <= game_over_d;
            winner     <= winner_d;
            scorer_r   <= scorer_r_nxt;
            serve_dir  <= serve_dir_nxt;
        end
    end

endmodule

// File: tb/tb_referee.sv
// Directed bench for referee with a rally-level reference model and literal spot checks.
module tb_referee;

    localparam int SM = 2;
    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  ball_x = 4'd7;
    logic [3:0]  ball_y = 4'd7;
    logic        ball_left = 1'b0;
    logic        ball_up = 1'b0;
    logic [15:0] lpaddle = 16'h0000;
    logic [15:0] rpaddle = 16'h0000;
    logic        restart = 1'b0;
    logic        bounce_x, bounce_y, serve, serve_left, freeze, game_over, winner;
    logic [3:0]  score_l, score_r;

    int total = 0;
    int bad = 0;

    referee #(.SCORE_MAX(SM), .SERVE_DELAY(SD), .DELAY_W(4)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .ball_x(ball_x), .ball_y(ball_y), .ball_left(ball_left), .ball_up(ball_up),
        .lpaddle(lpaddle), .rpaddle(rpaddle), .restart(restart),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .serve(serve), .serve_left(serve_left),
        .freeze(freeze), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting to serve, 1 = rally, 2 = point awarded, 3 = game over.
    int m_phase = 0;
    int m_cnt = SD;
    int m_sl = 0;
    int m_sr = 0;
    bit m_dir = 1'b0;
    bit m_scorer_r = 1'b0;
    bit m_lmiss, m_rmiss, m_lhit, m_rhit, m_wall;
    bit e_bx = 0, e_by = 0, e_serve = 0, e_sleft = 0, e_freeze = 1, e_go = 0, e_win = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_cnt = SD; m_sl = 0; m_sr = 0; m_dir = 0;
            e_bx = 0; e_by = 0; e_serve = 0; e_sleft = 0; e_freeze = 1; e_go = 0; e_win = 0;
        end else begin
            e_bx = 0; e_by = 0; e_serve = 0;
            case (m_phase)
                0: if (tick) begin
                    if (m_cnt == 1) begin
                        e_serve = 1; e_sleft = m_dir; e_freeze = 0; m_phase = 1;
                    end else begin
                        m_cnt--;
                    end
                end
                1: if (tick) begin
                    m_lhit  = (ball_x == 1) && ball_left && lpaddle[ball_y];
                    m_lmiss = (ball_x == 1) && ball_left && !lpaddle[ball_y];
                    m_rhit  = (ball_x == 14) && !ball_left && rpaddle[ball_y];
                    m_rmiss = (ball_x == 14) && !ball_left && !rpaddle[ball_y];
                    m_wall  = (ball_y == 0 && ball_up) || (ball_y == 15 && !ball_up);
                    e_bx = m_lhit || m_rhit;
                    e_by = m_wall && !(m_lmiss || m_rmiss);
                    if (m_lmiss || m_rmiss) begin
                        m_phase = 2; m_scorer_r = m_lmiss; e_freeze = 1;
                    end
                end
                2: begin
                    if (m_scorer_r && m_sr < SM) m_sr++;
                    if (!m_scorer_r && m_sl < SM) m_sl++;
                    m_dir = m_scorer_r;
                    if ((m_scorer_r ? m_sr : m_sl) == SM) begin
                        m_phase = 3; e_go = 1; e_win = m_scorer_r;
                    end else begin
                        m_phase = 0; m_cnt = SD;
                    end
                end
                default: if (restart) begin
                    m_sl = 0; m_sr = 0; m_dir = 0; e_go = 0; e_win = 0; m_phase = 0; m_cnt = SD;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("bounce_x", 16'(bounce_x), 16'(e_bx));
        chk("bounce_y", 16'(bounce_y), 16'(e_by));
        chk("serve", 16'(serve), 16'(e_serve));
        if (e_serve) chk("serve_left", 16'(serve_left), 16'(e_sleft));
        chk("freeze", 16'(freeze), 16'(e_freeze));
        chk("score_l", 16'(score_l), 16'(m_sl));
        chk("score_r", 16'(score_r), 16'(m_sr));
        chk("game_over", 16'(game_over), 16'(e_go));
        if (e_go) chk("winner", 16'(winner), 16'(e_win));
    end

    task automatic do_tick(input logic [3:0] x, input logic [3:0] y, input logic l, input logic u);
        @(negedge clk);
        ball_x = x; ball_y = y; ball_left = l; ball_up = u; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic countdown();
        for (int i = 0; i < SD; i++) do_tick(4'd7, 4'd7, 1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_freeze", 16'(freeze), 16'h1);
        chk("rst_serve", 16'(serve), 16'h0);
        chk("rst_scores", {8'h0, score_l, score_r}, 16'h0);
        reset = 1'b1;

        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        chk("no_serve_after_2", 16'(serve), 16'h0);
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        chk("serve_after_3", 16'(serve), 16'h1);
        chk("first_serve_dir", 16'(serve_left), 16'h0);
        chk("unfreeze", 16'(freeze), 16'h0);
        idle(1);
        chk("serve_one_cycle", 16'(serve), 16'h0);

        lpaddle = 16'h0020;
        do_tick(4'd1, 4'd5, 1'b1, 1'b0);
        chk("lpaddle_hit_bx", 16'(bounce_x), 16'h1);
        chk("lpaddle_hit_by", 16'(bounce_y), 16'h0);
        do_tick(4'd7, 4'd7, 1'b1, 1'b0);
        pulse_restart();

        lpaddle = 16'h0040;
        do_tick(4'd1, 4'd5, 1'b1, 1'b0);
        chk("miss_freeze", 16'(freeze), 16'h1);
        idle(1);
        chk("miss_score_r", 16'(score_r), 16'h1);
        countdown();
        chk("serve_toward_left", {15'h0, serve, serve_left}, 16'h3);

        rpaddle = 16'h8000;
        do_tick(4'd14, 4'd15, 1'b0, 1'b0);
        chk("corner_both", {14'h0, bounce_x, bounce_y}, 16'h3);

        lpaddle = 16'h0000;
        do_tick(4'd1, 4'd0, 1'b1, 1'b1);
        chk("miss_no_by", 16'(bounce_y), 16'h0);
        idle(1);
        chk("right_wins", {13'h0, game_over, winner, 1'b0}, 16'h6);
        chk("right_score2", 16'(score_r), 16'h2);
        pulse_restart();
        chk("restart_scores", {8'h0, score_l, score_r}, 16'h0);

        rpaddle = 16'h0000;
        for (int r = 0; r < 2; r++) begin
            countdown();
            chk("serve_right", {15'h0, serve, serve_left}, 16'h2);
            do_tick(4'd14, 4'd3, 1'b0, 1'b0);
            idle(1);
        end
        chk("left_wins", {13'h0, game_over, winner, 1'b0}, 16'h4);
        chk("left_score2", 16'(score_l), 16'h2);
        do_tick(4'd14, 4'd3, 1'b0, 1'b0);
        do_tick(4'd1, 4'd3, 1'b1, 1'b0);
        chk("over_ignores_ticks", {8'h0, score_l, score_r}, 16'h20);
        pulse_restart();
        chk("restart_clear", {7'h0, game_over, score_l, score_r}, 16'h0);

        countdown();
        do_tick(4'd14, 4'd3, 1'b0, 1'b0);
        idle(1);
        chk("score_l_one", 16'(score_l), 16'h1);
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rst_score", 16'(score_l), 16'h0);
        chk("async_rst_freeze", 16'(freeze), 16'h1);
        @(negedge clk);
        reset = 1'b1;
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        chk("restarted_count_2", 16'(serve), 16'h0);
        do_tick(4'd7, 4'd7, 1'b0, 1'b0);
        chk("restarted_count_3", 16'(serve), 16'h1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
